tcp_tx_msg_poller: RTL and testbench
====================================

Name: tcp_tx_msg_poller

Overview:
- Upstream feeder of the TX message NoC-interface output stage.
- Holds one outstanding app "request TX buffer space" entry per flow and scans pending flows round-robin.
- For each pending flow, reads that flow's TX payload buffer pointers and computes free space.
- When free space covers the requested length, emits one metadata beat (flowid, base_ptr, len, dst x/y/fbits) on the poller_msg_noc_if interface.

Parameters:
- NUM_FLOWS, default 1<<FLOWID_W: number of flow table entries. Must be a power of two, ≤ 1<<FLOWID_W.

Ports:
- clk  in  1  clock
- rst  in  1  asynchronous active-low reset (asserted at 0)
- app_poller_req_val  in  1  new buffer request valid
- app_poller_req_flowid  in  FLOWID_W  requesting flow
- app_poller_req_len  in  TX_PAYLOAD_PTR_W  bytes requested
- app_poller_req_dst_x  in  `XY_WIDTH  reply destination x
- app_poller_req_dst_y  in  `XY_WIDTH  reply destination y
- app_poller_req_dst_fbits  in  `NOC_FBITS_WIDTH  reply destination fbits
- poller_app_req_rdy  out  1  request accepted
- poller_ptr_rd_req_val  out  1  pointer read request
- poller_ptr_rd_req_flowid  out  FLOWID_W  flow to read
- ptr_poller_rd_req_rdy  in  1
- ptr_poller_rd_resp_val  in  1
- ptr_poller_rd_resp_head  in  TX_PAYLOAD_PTR_W+1  acked (freed-up-to) pointer
- ptr_poller_rd_resp_tail  in  TX_PAYLOAD_PTR_W+1  app write pointer
- poller_ptr_rd_resp_rdy  out  1
- poller_msg_noc_if_meta_val  out  1
- poller_msg_noc_if_flowid  out  FLOWID_W
- poller_msg_noc_if_base_ptr  out  TX_PAYLOAD_PTR_W+1
- poller_msg_noc_if_len  out  TX_PAYLOAD_PTR_W
- poller_msg_noc_if_dst_x  out  `XY_WIDTH
- poller_msg_noc_if_dst_y  out  `XY_WIDTH
- poller_msg_noc_if_dst_fbits  out  `NOC_FBITS_WIDTH
- noc_if_poller_msg_meta_rdy  in  1

Behaviour:
- Reset values:
  - all val outputs 0; pending[] all 0; rr_ptr 0; state IDLE; data outputs 0.
  - poller_app_req_rdy 0 during reset, otherwise as defined below.
- Request table:
  - poller_app_req_rdy = ~pending[app_poller_req_flowid] (combinational).
  - On val&rdy: store len/dst fields, set pending. Takes effect next cycle.
  - A second request to a pending flow stalls until that flow is served.
- Picker: combinational round-robin; selects the first pending flow at index ≥ rr_ptr, wrapping.
- FSM:
  - IDLE: if any pending, latch the picked flowid to cur_flow, go to RD_REQ.
  - RD_REQ: poller_ptr_rd_req_val=1 with cur_flow. On rdy, go to RD_RESP.
  - RD_RESP: poller_ptr_rd_resp_rdy=1. On val, register head/tail and compute:
    - used = (tail - head) mod 2^(W+1)
    - free = 2^W - used, in W+1 bits
    - If free ≥ stored len, go to META_OUT.
    - Else set rr_ptr = cur_flow+1 (mod NUM_FLOWS), go to IDLE. Entry stays pending.
  - META_OUT: meta_val=1. Fields are held stable while val:
    - flowid = cur_flow, base_ptr = tail, len = stored len, dst fields stored.
    - On rdy: clear pending[cur_flow], set rr_ptr = cur_flow+1, go to IDLE.
- Latency: request accepted in cycle t gives earliest meta_val at t+4 (IDLE t+1, RD_REQ t+2, RD_RESP t+3 with resp at once, META_OUT t+4).
- Only one flow is in flight at a time. A new request to another flow while in flight is accepted normally.
- Request write and pending-clear never hit the same entry in one cycle, because rdy=0 while pending.
- len=0 is always satisfiable; it emits base_ptr=tail, len=0.
- Max len = 2^W-1 < buffer size, so every request is eventually satisfiable as acks advance head.
- Pointer wrap: subtraction is modulo 2^(W+1). Example W=4: head=30, tail=2 gives used=4.
- used>2^W is illegal input; it is not checked and the result is undefined.
- Reset mid-operation: asynchronous return to reset values. An in-flight read response arriving after reset is ignored because resp_rdy=0 in IDLE.

Decomposition:
- Shared package tcp_tx_tile_defs: FLOWID_W, TX_PAYLOAD_PTR_W (existing); new poller_req_struct {len, dst_x, dst_y, dst_fbits}; poller_state_e enum.
- Split into _ctrl (FSM, handshakes) and _datap (table, pointer registers, free-space arithmetic), matching tile style.
- One sub-module: tcp_tx_msg_poller_rr_pick (pending vector + rr_ptr → any_val, picked index).

Test Plan:
- Single flow, W=4: req flow 3 len 5 dst (1,2,fbits 0xA); resp head=0 tail=0 → one meta: flowid 3, base_ptr 0, len 5, dst (1,2,0xA), first val 4 cycles after accept.
- Insufficient space: flow 1 len 10; head=0 tail=12 (free 4) → no meta, rd repeats. Then head=8 (free 12) → meta base_ptr 12, len 10.
- Round-robin: flows 0, 2, 5 pending, rr_ptr 0, all satisfiable → meta order 0, 2, 5. Re-request flow 0 during 2's service → order continues 5 then 0.
- Duplicate request: second req to pending flow 4 → rdy=0 until flow 4 meta handshake; accepted the cycle after.
- Backpressure: hold meta_rdy=0 for 6 cycles → val and all fields stable; pending cleared only on the handshake cycle.
- Wrap and reset: head=30 tail=2, len 12 → free 12 → meta base_ptr 2. Assert rst low in RD_RESP → all vals 0, pending cleared, later responses ignored.

Source files
------------

// File: rtl/tcp_tx_tile_defs.sv
// Shared TX tile definitions: widths, poller request entry and poller FSM states.
package tcp_tx_tile_defs;
    localparam int unsigned FLOWID_W         = 3;
    localparam int unsigned TX_PAYLOAD_PTR_W = 4;
    localparam int unsigned XY_WIDTH         = 8;
    localparam int unsigned NOC_FBITS_WIDTH  = 4;

    typedef struct packed {
        logic [TX_PAYLOAD_PTR_W-1:0] len;
        logic [XY_WIDTH-1:0]         dst_x;
        logic [XY_WIDTH-1:0]         dst_y;
        logic [NOC_FBITS_WIDTH-1:0]  dst_fbits;
    } poller_req_struct;

    typedef enum logic [1:0] {StIdle, StRdReq, StRdResp, StMetaOut} poller_state_e;

    // Pointers carry one extra wrap bit, so occupancy is a plain modular difference.
    function automatic logic [TX_PAYLOAD_PTR_W:0] tx_free_space(
        input logic [TX_PAYLOAD_PTR_W:0] head,
        input logic [TX_PAYLOAD_PTR_W:0] tail
    );
        logic [TX_PAYLOAD_PTR_W:0] used;
        used = tail - head;
        return {1'b1, {TX_PAYLOAD_PTR_W{1'b0}}} - used;
    endfunction
endpackage

// File: rtl/tcp_tx_msg_poller_ctrl.sv
// Poller control FSM: pointer read handshake, meta handshake and round-robin pointer.
module tcp_tx_msg_poller_ctrl
    import tcp_tx_tile_defs::*;
#(
    parameter int unsigned NUM_FLOWS = 1 << FLOWID_W
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                any_val,
    input  logic [FLOWID_W-1:0] picked,
    input  logic                ptr_rd_req_rdy,
    input  logic                ptr_rd_resp_val,
    input  logic                fits,
    input  logic                meta_rdy,
    output logic [FLOWID_W-1:0] cur_flow,
    output logic [FLOWID_W-1:0] rr_ptr,
    output logic                rd_req_val,
    output logic                rd_resp_rdy,
    output logic                meta_val,
    output logic                resp_take,
    output logic                meta_done
);
    localparam logic [FLOWID_W-1:0] FLOW_MASK = FLOWID_W'(NUM_FLOWS - 1);

    poller_state_e       state_q, state_d;
    logic [FLOWID_W-1:0] cur_flow_q, cur_flow_d;
    logic [FLOWID_W-1:0] rr_ptr_q, rr_ptr_d;
    logic [FLOWID_W-1:0] next_flow;

    assign next_flow = (cur_flow_q + FLOWID_W'(1)) & FLOW_MASK;
    assign cur_flow  = cur_flow_q;
    assign rr_ptr    = rr_ptr_q;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q    <= StIdle;
            cur_flow_q <= '0;
            rr_ptr_q   <= '0;
        end else begin
            state_q    <= state_d;
            cur_flow_q <= cur_flow_d;
            rr_ptr_q   <= rr_ptr_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        cur_flow_d  = cur_flow_q;
        rr_ptr_d    = rr_ptr_q;
        rd_req_val  = 1'b0;
        rd_resp_rdy = 1'b0;
        meta_val    = 1'b0;
        resp_take   = 1'b0;
        meta_done   = 1'b0;
        case (state_q)
            StIdle: begin
                if (any_val) begin
                    cur_flow_d = picked;
                    state_d    = StRdReq;
                end
            end
            StRdReq: begin
                rd_req_val = 1'b1;
                if (ptr_rd_req_rdy) state_d = StRdResp;
            end
            StRdResp: begin
                rd_resp_rdy = 1'b1;
                if (ptr_rd_resp_val) begin
                    resp_take = 1'b1;
                    if (fits) begin
                        state_d = StMetaOut;
                    end else begin
                        // Entry stays pending; move on so other flows are not starved.
                        rr_ptr_d = next_flow;
                        state_d  = StIdle;
                    end
                end
            end
            StMetaOut: begin
                meta_val = 1'b1;
                if (meta_rdy) begin
                    meta_done = 1'b1;
                    rr_ptr_d  = next_flow;
                    state_d   = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end
endmodule

// File: rtl/tcp_tx_msg_poller_datap.sv
// Poller datapath: per-flow request table, pending bits, tail register, free-space test.
module tcp_tx_msg_poller_datap
    import tcp_tx_tile_defs::*;
#(
    parameter int unsigned NUM_FLOWS = 1 << FLOWID_W
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        req_val,
    input  logic [FLOWID_W-1:0]         req_flowid,
    input  poller_req_struct            req_entry,
    output logic                        req_rdy,
    input  logic                        meta_done,
    input  logic [FLOWID_W-1:0]         cur_flow,
    input  logic                        resp_take,
    input  logic [TX_PAYLOAD_PTR_W:0]   resp_head,
    input  logic [TX_PAYLOAD_PTR_W:0]   resp_tail,
    output logic [NUM_FLOWS-1:0]        pending,
    output logic                        fits,
    output logic [TX_PAYLOAD_PTR_W:0]   base_ptr,
    output poller_req_struct            cur_entry
);
    logic [NUM_FLOWS-1:0]      pending_q;
    poller_req_struct          entry_q [NUM_FLOWS];
    logic [TX_PAYLOAD_PTR_W:0] tail_q;
    logic                      req_we;

    // Held low in reset so no request is taken while the table is being cleared.
    assign req_rdy   = rst & ~pending_q[req_flowid];
    assign req_we    = req_val & req_rdy;
    assign pending   = pending_q;
    assign cur_entry = entry_q[cur_flow];
    assign base_ptr  = tail_q;
    assign fits      = tx_free_space(resp_head, resp_tail) >= {1'b0, cur_entry.len};

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            pending_q <= '0;
            tail_q    <= '0;
            for (int unsigned i = 0; i < NUM_FLOWS; i++) entry_q[i] <= '0;
        end else begin
            if (req_we) begin
                entry_q[req_flowid]   <= req_entry;
                pending_q[req_flowid] <= 1'b1;
            end
            if (meta_done) pending_q[cur_flow] <= 1'b0;
            if (resp_take) tail_q <= resp_tail;
        end
    end
endmodule

// File: rtl/tcp_tx_msg_poller_rr_pick.sv
// Round-robin picker: first pending flow at or after rr_ptr, wrapping.
module tcp_tx_msg_poller_rr_pick
    import tcp_tx_tile_defs::*;
#(
    parameter int unsigned NUM_FLOWS = 1 << FLOWID_W
) (
    input  logic [NUM_FLOWS-1:0] pending,
    input  logic [FLOWID_W-1:0]  rr_ptr,
    output logic                 any_val,
    output logic [FLOWID_W-1:0]  picked
);
    localparam logic [FLOWID_W-1:0] FLOW_MASK = FLOWID_W'(NUM_FLOWS - 1);

    always_comb begin
        logic [FLOWID_W-1:0] idx;
        any_val = 1'b0;
        picked  = '0;
        idx     = '0;
        for (int unsigned i = 0; i < NUM_FLOWS; i++) begin
            idx = (rr_ptr + FLOWID_W'(i)) & FLOW_MASK;
            if (!any_val && pending[idx]) begin
                any_val = 1'b1;
                picked  = idx;
            end
        end
    end
endmodule

// File: rtl/tcp_tx_msg_poller.sv
// TX message poller: scans pending buffer requests and emits metadata once space is free.
module tcp_tx_msg_poller
    import tcp_tx_tile_defs::*;
#(
    parameter int unsigned NUM_FLOWS = 1 << FLOWID_W
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          app_poller_req_val,
    input  logic [FLOWID_W-1:0]           app_poller_req_flowid,
    input  logic [TX_PAYLOAD_PTR_W-1:0]   app_poller_req_len,
    input  logic [XY_WIDTH-1:0]           app_poller_req_dst_x,
    input  logic [XY_WIDTH-1:0]           app_poller_req_dst_y,
    input  logic [NOC_FBITS_WIDTH-1:0]    app_poller_req_dst_fbits,
    output logic                          poller_app_req_rdy,
    output logic                          poller_ptr_rd_req_val,
    output logic [FLOWID_W-1:0]           poller_ptr_rd_req_flowid,
    input  logic                          ptr_poller_rd_req_rdy,
    input  logic                          ptr_poller_rd_resp_val,
    input  logic [TX_PAYLOAD_PTR_W:0]     ptr_poller_rd_resp_head,
    input  logic [TX_PAYLOAD_PTR_W:0]     ptr_poller_rd_resp_tail,
    output logic                          poller_ptr_rd_resp_rdy,
    output logic                          poller_msg_noc_if_meta_val,
    output logic [FLOWID_W-1:0]           poller_msg_noc_if_flowid,
    output logic [TX_PAYLOAD_PTR_W:0]     poller_msg_noc_if_base_ptr,
    output logic [TX_PAYLOAD_PTR_W-1:0]   poller_msg_noc_if_len,
    output logic [XY_WIDTH-1:0]           poller_msg_noc_if_dst_x,
    output logic [XY_WIDTH-1:0]           poller_msg_noc_if_dst_y,
    output logic [NOC_FBITS_WIDTH-1:0]    poller_msg_noc_if_dst_fbits,
    input  logic                          noc_if_poller_msg_meta_rdy
);
    poller_req_struct      req_entry;
    poller_req_struct      cur_entry;
    logic [NUM_FLOWS-1:0]  pending;
    logic                  any_val;
    logic [FLOWID_W-1:0]   picked;
    logic [FLOWID_W-1:0]   rr_ptr;
    logic [FLOWID_W-1:0]   cur_flow;
    logic                  fits;
    logic                  resp_take;
    logic                  meta_done;

    assign req_entry = '{len:       app_poller_req_len,
                         dst_x:     app_poller_req_dst_x,
                         dst_y:     app_poller_req_dst_y,
                         dst_fbits: app_poller_req_dst_fbits};

    assign poller_ptr_rd_req_flowid    = cur_flow;
    assign poller_msg_noc_if_flowid    = cur_flow;
    assign poller_msg_noc_if_len       = cur_entry.len;
    assign poller_msg_noc_if_dst_x     = cur_entry.dst_x;
    assign poller_msg_noc_if_dst_y     = cur_entry.dst_y;
    assign poller_msg_noc_if_dst_fbits = cur_entry.dst_fbits;

    tcp_tx_msg_poller_rr_pick #(.NUM_FLOWS(NUM_FLOWS)) u_rr_pick (
        .pending (pending),
        .rr_ptr  (rr_ptr),
        .any_val (any_val),
        .picked  (picked)
    );

    tcp_tx_msg_poller_ctrl #(.NUM_FLOWS(NUM_FLOWS)) u_ctrl (
        .clk             (clk),
        .rst             (rst),
        .any_val         (any_val),
        .picked          (picked),
        .ptr_rd_req_rdy  (ptr_poller_rd_req_rdy),
        .ptr_rd_resp_val (ptr_poller_rd_resp_val),
        .fits            (fits),
        .meta_rdy        (noc_if_poller_msg_meta_rdy),
        .cur_flow        (cur_flow),
        .rr_ptr          (rr_ptr),
        .rd_req_val      (poller_ptr_rd_req_val),
        .rd_resp_rdy     (poller_ptr_rd_resp_rdy),
        .meta_val        (poller_msg_noc_if_meta_val),
        .resp_take       (resp_take),
        .meta_done       (meta_done)
    );

    tcp_tx_msg_poller_datap #(.NUM_FLOWS(NUM_FLOWS)) u_datap (
        .clk        (clk),
        .rst        (rst),
        .req_val    (app_poller_req_val),
        .req_flowid (app_poller_req_flowid),
        .req_entry  (req_entry),
        .req_rdy    (poller_app_req_rdy),
        .meta_done  (meta_done),
        .cur_flow   (cur_flow),
        .resp_take  (resp_take),
        .resp_head  (ptr_poller_rd_resp_head),
        .resp_tail  (ptr_poller_rd_resp_tail),
        .pending    (pending),
        .fits       (fits),
        .base_ptr   (poller_msg_noc_if_base_ptr),
        .cur_entry  (cur_entry)
    );
endmodule

// File: tb/tb_tcp_tx_msg_poller.sv
// Directed bench for tcp_tx_msg_poller: vector table plus hand-written corner sequences.
module tb_tcp_tx_msg_poller;
    import tcp_tx_tile_defs::*;

    localparam int W = TX_PAYLOAD_PTR_W;

    logic                        clk = 1'b0;
    logic                        rst;
    logic                        app_poller_req_val;
    logic [FLOWID_W-1:0]         app_poller_req_flowid;
    logic [W-1:0]                app_poller_req_len;
    logic [XY_WIDTH-1:0]         app_poller_req_dst_x;
    logic [XY_WIDTH-1:0]         app_poller_req_dst_y;
    logic [NOC_FBITS_WIDTH-1:0]  app_poller_req_dst_fbits;
    logic                        poller_app_req_rdy;
    logic                        poller_ptr_rd_req_val;
    logic [FLOWID_W-1:0]         poller_ptr_rd_req_flowid;
    logic                        ptr_poller_rd_req_rdy;
    logic                        ptr_poller_rd_resp_val;
    logic [W:0]                  ptr_poller_rd_resp_head;
    logic [W:0]                  ptr_poller_rd_resp_tail;
    logic                        poller_ptr_rd_resp_rdy;
    logic                        meta_val;
    logic [FLOWID_W-1:0]         meta_flowid;
    logic [W:0]                  meta_base;
    logic [W-1:0]                meta_len;
    logic [XY_WIDTH-1:0]         meta_dx;
    logic [XY_WIDTH-1:0]         meta_dy;
    logic [NOC_FBITS_WIDTH-1:0]  meta_fb;
    logic                        meta_rdy;

    tcp_tx_msg_poller dut (
        .clk                         (clk),
        .rst                         (rst),
        .app_poller_req_val          (app_poller_req_val),
        .app_poller_req_flowid       (app_poller_req_flowid),
        .app_poller_req_len          (app_poller_req_len),
        .app_poller_req_dst_x        (app_poller_req_dst_x),
        .app_poller_req_dst_y        (app_poller_req_dst_y),
        .app_poller_req_dst_fbits    (app_poller_req_dst_fbits),
        .poller_app_req_rdy          (poller_app_req_rdy),
        .poller_ptr_rd_req_val       (poller_ptr_rd_req_val),
        .poller_ptr_rd_req_flowid    (poller_ptr_rd_req_flowid),
        .ptr_poller_rd_req_rdy       (ptr_poller_rd_req_rdy),
        .ptr_poller_rd_resp_val      (ptr_poller_rd_resp_val),
        .ptr_poller_rd_resp_head     (ptr_poller_rd_resp_head),
        .ptr_poller_rd_resp_tail     (ptr_poller_rd_resp_tail),
        .poller_ptr_rd_resp_rdy      (poller_ptr_rd_resp_rdy),
        .poller_msg_noc_if_meta_val  (meta_val),
        .poller_msg_noc_if_flowid    (meta_flowid),
        .poller_msg_noc_if_base_ptr  (meta_base),
        .poller_msg_noc_if_len       (meta_len),
        .poller_msg_noc_if_dst_x     (meta_dx),
        .poller_msg_noc_if_dst_y     (meta_dy),
        .poller_msg_noc_if_dst_fbits (meta_fb),
        .noc_if_poller_msg_meta_rdy  (meta_rdy)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int failures = 0;
    int cyc = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Pointer-table model: answers each read with that flow's head/tail.
    logic [W:0] mem_head [8];
    logic [W:0] mem_tail [8];
    int rd_flow = 0;
    int rd_cnt = 0;
    bit resp_en = 1'b1;
    bit resp_force = 1'b0;

    always @(posedge clk) begin
        if (poller_ptr_rd_req_val && ptr_poller_rd_req_rdy) begin
            rd_flow <= int'(poller_ptr_rd_req_flowid);
            rd_cnt  <= rd_cnt + 1;
        end
    end

    always @(negedge clk) begin
        ptr_poller_rd_resp_val  = (resp_en && poller_ptr_rd_resp_rdy) || resp_force;
        ptr_poller_rd_resp_head = mem_head[rd_flow];
        ptr_poller_rd_resp_tail = mem_tail[rd_flow];
    end

    typedef struct {
        int flow; int base; int len; int dx; int dy; int fb; int cyc;
    } meta_rec_t;
    meta_rec_t mq[$];

    always @(negedge clk) begin : mon
        meta_rec_t r;
        if (rst && meta_val && meta_rdy) begin
            r.flow = int'(meta_flowid);
            r.base = int'(meta_base);
            r.len  = int'(meta_len);
            r.dx   = int'(meta_dx);
            r.dy   = int'(meta_dy);
            r.fb   = int'(meta_fb);
            r.cyc  = cyc;
            mq.push_back(r);
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send_req(input int flow, input int len, input int dx, input int dy,
                            input int fb, output int acc);
        app_poller_req_val       = 1'b1;
        app_poller_req_flowid    = FLOWID_W'(flow);
        app_poller_req_len       = W'(len);
        app_poller_req_dst_x     = XY_WIDTH'(dx);
        app_poller_req_dst_y     = XY_WIDTH'(dy);
        app_poller_req_dst_fbits = NOC_FBITS_WIDTH'(fb);
        acc = -1;
        for (int k = 0; k < 40; k++) begin
            @(negedge clk);
            if (poller_app_req_rdy) begin
                acc = cyc;
                break;
            end
        end
        if (acc < 0) check("req_accept_timeout", 64'd0, 64'd1);
        tick();
        app_poller_req_val = 1'b0;
    endtask

    task automatic wait_metas(input int n, input int budget, input string name);
        for (int k = 0; k < budget; k++) begin
            if (mq.size() >= n) break;
            tick();
        end
        check(name, 64'(mq.size()), 64'(n));
    endtask

    task automatic pulse_reset();
        @(negedge clk);
        rst = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b1;
        tick();
    endtask

    typedef struct {
        int flow; int len; int dx; int dy; int fb; int head; int tail; int exp_base;
    } vec_t;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        vec_t      vecs[5];
        meta_rec_t r;
        int        acc, base, r0, hs, acc2, m0;
        bit        bad;

        vecs[0] = '{3,  5, 1,    2,    'hA, 0,  0,  0};
        vecs[1] = '{6, 15, 3,    4,    'h5, 7,  7,  7};
        vecs[2] = '{0,  0, 'hFF, 'h80, 'hF, 10, 25, 25};
        vecs[3] = '{7, 12, 9,    9,    'h1, 30, 2,  2};
        vecs[4] = '{2,  1, 'h11, 'h22, 'h3, 16, 31, 31};

        for (int i = 0; i < 8; i++) begin
            mem_head[i] = '0;
            mem_tail[i] = '0;
        end
        rst = 1'b0;
        app_poller_req_val = 1'b0;
        app_poller_req_flowid = '0;
        app_poller_req_len = '0;
        app_poller_req_dst_x = '0;
        app_poller_req_dst_y = '0;
        app_poller_req_dst_fbits = '0;
        ptr_poller_rd_req_rdy = 1'b1;
        meta_rdy = 1'b1;

        // Reset state
        repeat (3) @(posedge clk);
        #1;
        check("rst_app_rdy", 64'(poller_app_req_rdy), 64'd0);
        check("rst_rd_req_val", 64'(poller_ptr_rd_req_val), 64'd0);
        check("rst_resp_rdy", 64'(poller_ptr_rd_resp_rdy), 64'd0);
        check("rst_meta_val", 64'(meta_val), 64'd0);
        check("rst_meta_fields", {meta_flowid, meta_base, meta_len, meta_dx, meta_dy, meta_fb},
              64'd0);
        @(negedge clk);
        rst = 1'b1;
        tick();
        check("post_rst_app_rdy", 64'(poller_app_req_rdy), 64'd1);

        // Single-flow vectors, all satisfiable on the first read
        for (int i = 0; i < 5; i++) begin
            mem_head[vecs[i].flow] = (W+1)'(vecs[i].head);
            mem_tail[vecs[i].flow] = (W+1)'(vecs[i].tail);
            base = mq.size();
            send_req(vecs[i].flow, vecs[i].len, vecs[i].dx, vecs[i].dy, vecs[i].fb, acc);
            wait_metas(base + 1, 20, "vec_meta_count");
            if (mq.size() > base) begin
                r = mq[base];
                check("vec_flowid", 64'(r.flow), 64'(vecs[i].flow));
                check("vec_base_ptr", 64'(r.base), 64'(vecs[i].exp_base));
                check("vec_len", 64'(r.len), 64'(vecs[i].len));
                check("vec_dst", {16'(r.dx), 16'(r.dy), 16'(r.fb)},
                      {16'(vecs[i].dx), 16'(vecs[i].dy), 16'(vecs[i].fb)});
                check("vec_latency", 64'(r.cyc - acc), 64'd4);
            end
        end

        // Insufficient space: retries until head advances
        mem_head[1] = 5'd0;
        mem_tail[1] = 5'd12;
        base = mq.size();
        r0 = rd_cnt;
        send_req(1, 10, 4, 4, 2, acc);
        repeat (12) tick();
        check("insuff_no_meta", 64'(mq.size()), 64'(base));
        check("insuff_rd_repeat", 64'(rd_cnt - r0 >= 3), 64'd1);
        mem_head[1] = 5'd8;
        wait_metas(base + 1, 20, "insuff_meta_count");
        if (mq.size() > base) begin
            check("insuff_flowid", 64'(mq[base].flow), 64'd1);
            check("insuff_base_ptr", 64'(mq[base].base), 64'd12);
            check("insuff_len", 64'(mq[base].len), 64'd10);
        end

        // Round-robin order from rr_ptr 0, with flow 0 re-requested mid-stream
        pulse_reset();
        mem_head[0] = 5'd1; mem_tail[0] = 5'd1;
        mem_head[2] = 5'd2; mem_tail[2] = 5'd2;
        mem_head[5] = 5'd5; mem_tail[5] = 5'd5;
        base = mq.size();
        send_req(0, 1, 0, 0, 0, acc);
        send_req(2, 1, 0, 0, 0, acc);
        send_req(5, 1, 0, 0, 0, acc);
        wait_metas(base + 1, 20, "rr_first_meta");
        mem_head[0] = 5'd3; mem_tail[0] = 5'd3;
        send_req(0, 2, 0, 0, 0, acc);
        wait_metas(base + 4, 40, "rr_meta_count");
        if (mq.size() >= base + 4) begin
            check("rr_order0", 64'(mq[base].flow), 64'd0);
            check("rr_order1", 64'(mq[base + 1].flow), 64'd2);
            check("rr_order2", 64'(mq[base + 2].flow), 64'd5);
            check("rr_order3", 64'(mq[base + 3].flow), 64'd0);
            check("rr_reissue_base", 64'(mq[base + 3].base), 64'd3);
            check("rr_reissue_len", 64'(mq[base + 3].len), 64'd2);
        end

        // Backpressure with a duplicate request to the in-flight flow
        mem_head[4] = 5'd0;
        mem_tail[4] = 5'd9;
        meta_rdy = 1'b0;
        base = mq.size();
        send_req(4, 3, 5, 6, 7, acc);
        for (int k = 0; k < 20; k++) begin
            if (meta_val) break;
            tick();
        end
        check("bp_val_rise", 64'(meta_val), 64'd1);
        app_poller_req_val       = 1'b1;
        app_poller_req_flowid    = 3'd4;
        app_poller_req_len       = 4'd2;
        app_poller_req_dst_x     = 8'd8;
        app_poller_req_dst_y     = 8'd9;
        app_poller_req_dst_fbits = 4'd3;
        for (int k = 0; k < 6; k++) begin
            @(negedge clk);
            check("bp_stable", {meta_val, meta_flowid, meta_base, meta_len, meta_dx, meta_dy, meta_fb},
                  {1'b1, 3'd4, 5'd9, 4'd3, 8'd5, 8'd6, 4'd7});
            check("dup_rdy_low", 64'(poller_app_req_rdy), 64'd0);
        end
        tick();
        meta_rdy = 1'b1;
        hs = -1;
        acc2 = -1;
        for (int k = 0; k < 10; k++) begin
            @(negedge clk);
            if (hs < 0 && meta_val && meta_rdy) begin
                hs = cyc;
                check("dup_rdy_at_hs", 64'(poller_app_req_rdy), 64'd0);
            end else if (hs >= 0 && poller_app_req_rdy) begin
                acc2 = cyc;
                break;
            end
        end
        tick();
        app_poller_req_val = 1'b0;
        check("dup_accept_cycle", 64'(acc2), 64'(hs + 1));
        wait_metas(base + 2, 20, "dup_meta_count");
        if (mq.size() >= base + 2) begin
            check("bp_first_len", 64'(mq[base].len), 64'd3);
            check("dup_second", {16'(mq[base + 1].flow), 16'(mq[base + 1].len),
                                 16'(mq[base + 1].dx), 16'(mq[base + 1].base)},
                  {16'd4, 16'd2, 16'd8, 16'd9});
        end

        // Asynchronous reset while waiting in RD_RESP; stale responses ignored
        resp_en = 1'b0;
        mem_head[6] = 5'd0;
        mem_tail[6] = 5'd0;
        send_req(6, 1, 1, 1, 1, acc);
        send_req(2, 1, 1, 1, 1, acc);
        for (int k = 0; k < 20; k++) begin
            if (poller_ptr_rd_resp_rdy) break;
            tick();
        end
        check("rst_reach_rdresp", 64'(poller_ptr_rd_resp_rdy), 64'd1);
        #2;
        rst = 1'b0;
        #1;
        check("midrst_resp_rdy", 64'(poller_ptr_rd_resp_rdy), 64'd0);
        check("midrst_rd_req_val", 64'(poller_ptr_rd_req_val), 64'd0);
        check("midrst_meta_val", 64'(meta_val), 64'd0);
        check("midrst_app_rdy", 64'(poller_app_req_rdy), 64'd0);
        check("midrst_base_ptr", 64'(meta_base), 64'd0);
        @(negedge clk);
        rst = 1'b1;
        resp_en = 1'b1;
        resp_force = 1'b1;
        m0 = mq.size();
        bad = 1'b0;
        for (int k = 0; k < 8; k++) begin
            @(negedge clk);
            if (meta_val || poller_ptr_rd_req_val || poller_ptr_rd_resp_rdy) bad = 1'b1;
        end
        check("postrst_idle", 64'(bad), 64'd0);
        check("postrst_no_meta", 64'(mq.size()), 64'(m0));
        app_poller_req_flowid = 3'd6;
        #1;
        check("postrst_flow6_free", 64'(poller_app_req_rdy), 64'd1);
        app_poller_req_flowid = 3'd2;
        #1;
        check("postrst_flow2_free", 64'(poller_app_req_rdy), 64'd1);
        resp_force = 1'b0;

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
